// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer: packs GMII bytes into BYTES-wide words and releases a
// frame only after it is committed. Define RX_FRAME_BUFFER_STATS_EN to enable frame/drop counters.
module rx_frame_buffer #(
    parameter int unsigned BYTES = 4,
    parameter int unsigned DEPTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data_i,
    input  logic               in_valid_i,
    input  logic               in_last_i,
    input  logic               err_i,
    output logic [8*BYTES-1:0] out_data_o,
    output logic [BYTES-1:0]   out_keep_o,
    output logic               out_last_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               overflow_o,
    output logic [15:0]        drop_count_o,
    output logic [15:0]        frame_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned DW = 8 * BYTES;
    localparam int unsigned MW = DW + BYTES + 1;

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e            state_q;
    logic [PW-1:0]     wr_ptr_q, cmt_ptr_q, rd_ptr_q;
    logic [DW-1:0]     pack_q;
    logic [LW-1:0]     lane_q;
    logic [MW-1:0]     mem [DEPTH];

    logic [DW-1:0]     out_data_q;
    logic [BYTES-1:0]  out_keep_q;
    logic              out_last_q, out_valid_q, overflow_q;

    logic              accept, frame_end, word_wr, full, empty, load;
    logic              err_drop, ovf_drop, abort, drop, commit;
    logic [DW-1:0]     word_data;
    logic [BYTES-1:0]  word_keep;

    always_comb begin
        accept    = in_valid_i && (state_q != StDrop);
        frame_end = accept && in_last_i;
        word_data = pack_q;
        word_data[{lane_q, 3'b000} +: 8] = in_data_i;
        word_keep = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            word_keep[i] = (i <= 32'(lane_q));
        end
        word_wr  = accept && ((lane_q == LW'(BYTES - 1)) || in_last_i);
        // Occupancy counts speculative words too, against the pre-read rd_ptr.
        full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        err_drop = (state_q == StRecv) && err_i;
        ovf_drop = word_wr && full;
        abort    = (state_q == StRecv) && !in_valid_i;
        drop     = err_drop || ovf_drop || abort;
        commit   = frame_end && !drop;
        empty    = (rd_ptr_q == cmt_ptr_q);
        load     = !empty && (!out_valid_q || out_ready_i);
    end

    always_ff @(posedge clk) begin
        if (word_wr && !full && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_last_i, word_keep, word_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            pack_q     <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= ovf_drop;
            if (drop) begin
                wr_ptr_q <= cmt_ptr_q;
                pack_q   <= '0;
                lane_q   <= '0;
                state_q  <= (frame_end || abort) ? StIdle : StDrop;
            end else begin
                if (accept) begin
                    if (word_wr) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        pack_q   <= '0;
                        lane_q   <= '0;
                    end else begin
                        pack_q   <= word_data;
                        lane_q   <= lane_q + 1'b1;
                    end
                end
                // The final word is written this cycle, so publish the pointer past it.
                if (commit) begin
                    cmt_ptr_q <= wr_ptr_q + 1'b1;
                end
                case (state_q)
                    StIdle:  if (in_valid_i && !in_last_i) state_q <= StRecv;
                    StRecv:  if (frame_end) state_q <= StIdle;
                    StDrop:  if (!in_valid_i || in_last_i) state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Registered read doubles as the output stage; refills whenever it empties or transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            {out_last_q, out_keep_q, out_data_q} <= mem[rd_ptr_q[AW-1:0]];
            out_valid_q <= 1'b1;
            rd_ptr_q    <= rd_ptr_q + 1'b1;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;
    assign overflow_o  = overflow_q;

`ifdef RX_FRAME_BUFFER_STATS_EN
    logic [15:0] drop_cnt_q, frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (commit && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign drop_count_o  = drop_cnt_q;
    assign frame_count_o = frame_cnt_q;
`else
    assign drop_count_o  = '0;
    assign frame_count_o = '0;
`endif

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 BYTES, 4, output word width in bytes; legal values 1, 2, 4, 8.
REQ-002 DEPTH, 512, buffer depth in words; power of two, at least 16.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data_i  input  8  received byte, as on the GMII receive stream.
REQ-006 in_valid_i  input  1  byte strobe; high for every byte of a frame; no backpressure.
REQ-007 in_last_i  input  1  qualifies the final byte of a frame; ignored unless in_valid_i=1.
REQ-008 err_i  input  1  frame-invalid pulse (FCS or parser error) from the invalidate stage.
REQ-009 out_data_o  output  8*BYTES  packed frame word; first byte in bits 7:0.
REQ-010 out_keep_o  output  BYTES  byte-lane valid mask; all ones except possibly on out_last_o.
REQ-011 out_last_o  output  1  marks the final word of a frame.
REQ-012 out_valid_o  output  1  output word is valid.
REQ-013 out_ready_i  input  1  downstream accept; a transfer occurs when out_valid_o and out_ready_i are both 1.
REQ-014 overflow_o  output  1  one-cycle pulse when a frame is dropped for lack of space.
REQ-015 drop_count_o  output  16  saturating count of dropped frames.
REQ-016 frame_count_o  output  16  saturating count of committed frames.

Function
REQ-017 The block SHALL be a store-and-forward buffer: no word of a frame becomes visible at the output until the whole frame is committed.
REQ-018 Pointers: wr_ptr (speculative), cmt_ptr (committed) and rd_ptr, each log2(DEPTH)+1 bits wide, with natural wrap-around.
REQ-019 Full is defined as wr_ptr-rd_ptr==DEPTH; empty is defined as rd_ptr==cmt_ptr.
REQ-020 Byte packing: bytes fill lanes 0..BYTES-1 in order; a word is written when all BYTES lanes are filled, or on in_last_i with partial keep.
REQ-021 State machine states: IDLE, RECV, DROP.
REQ-022 IDLE->RECV on in_valid_i=1; that first byte is stored.
REQ-023 RECV->IDLE on in_valid_i & in_last_i with no error: commit by setting cmt_ptr to wr_ptr (including the flushed final word) on the following cycle, and increment frame_count_o.
REQ-024 Drop conditions in RECV: err_i=1 on any cycle up to and including the in_last_i cycle, a word write while full, or in_valid_i=0 before in_last_i (aborted frame).
REQ-025 On any drop condition: wr_ptr rolls back to cmt_ptr, the packer is cleared, and drop_count_o increments once per frame.
REQ-026 After a drop, the block SHALL enter DROP unless the drop occurred on the in_last_i cycle or on an abort, in which case it enters IDLE.
REQ-027 overflow_o SHALL pulse only for full-caused drops.
REQ-028 DROP discards bytes until in_valid_i & in_last_i, or until in_valid_i=0, then returns to IDLE.
REQ-029 err_i in IDLE or DROP SHALL be ignored.
REQ-030 Commit-to-output latency: with the buffer empty, out_valid_o SHALL assert exactly 2 cycles after the in_last_i cycle.
REQ-031 Memory read is registered with a one-word prefetch so that back-to-back transfers sustain one word per cycle.
REQ-032 When out_valid_o=1 and out_ready_i=0, out_data_o, out_keep_o and out_last_o SHALL hold stable.
REQ-033 A simultaneous write (commit) and read SHALL both take effect in the same cycle; the full check uses the pre-read rd_ptr.
REQ-034 Back-to-back frames with no idle gap SHALL be accepted: a commit and the next frame's first byte may occur in the same cycle.
REQ-035 drop_count_o and frame_count_o SHALL saturate at 16'hFFFF.

Reset
REQ-036 While rst=1: state=IDLE; all pointers and the packer are cleared; out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, overflow_o=0; counters=0.
REQ-037 A reset asserted mid-frame SHALL discard the partial frame and all buffered frames.
REQ-038 The first byte SHALL be accepted on the first cycle after rst deasserts.

Configuration
REQ-039 Macro RX_FRAME_BUFFER_STATS_EN defined: drop_count_o and frame_count_o are implemented as specified.
REQ-040 Macro RX_FRAME_BUFFER_STATS_EN undefined: both counters are tied to 0 and no counter registers exist; all other behaviour is unchanged.

Verification
REQ-041 BYTES=4, 64-byte frame 0x00..0x3F, out_ready_i=1 -> 16 words, first word 0x03020100, out_last_o on word 16 with keep=4'hF, out_valid_o asserts 2 cycles after in_last_i, frame_count_o=1.
REQ-042 BYTES=4, 61-byte frame -> 16 words, final keep=4'b0001 holding byte 0x3C.
REQ-043 err_i pulsed on the in_last_i cycle of a 64-byte frame -> no output, drop_count_o=1, and the next good frame is output intact.
REQ-044 DEPTH=16, BYTES=4, out_ready_i=0, 80-byte frame -> overflow_o pulses once, DROP until in_last_i, drop_count_o=1, buffer empty.
REQ-045 Two back-to-back 64-byte frames with out_ready_i toggling 1,0 -> 32 words in order, data stable while stalled.
REQ-046 rst asserted after byte 20 of a frame -> outputs at reset values, the next frame is received correctly; with the macro undefined, counters read 0 throughout.
